gost89_ecb_stream_ctrl: RTL and testbench

Streaming controller for the fully pipelined GOST 28147-89 ECB encrypt and decrypt datapaths. Accepts 64-bit blocks with a per-block mode (encrypt/decrypt) and tag over a valid/ready interface and feeds both non-stallable pipelines from one shared input bus. Tracks in-flight blocks with a valid/mode shift register and collects results into a credit-protected output FIFO. Key and S-box updates drain the pipelines before the new values are applied, so no block is ever processed with mixed key material.

---
 rtl/gost89_ecb_stream_ctrl.sv | 159 +++++++++++++++
 tb/tb_gost89_ecb_stream_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost89_ecb_stream_ctrl.sv
// Stream controller feeding the GOST 28147-89 ECB encrypt/decrypt pipelines.
// Tracks in-flight blocks, collects results in a credit-guarded output FIFO.
module gost89_ecb_stream_ctrl #(
    parameter int LATENCY    = 65,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load_valid,
    output logic             key_load_ready,
    input  logic [255:0]     key_in,
    input  logic [511:0]     sbox_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [63:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode,
    output logic [255:0]     pipe_key,
    output logic [511:0]     pipe_sbox,
    output logic [63:0]      pipe_in,
    input  logic [63:0]      enc_out,
    input  logic [63:0]      dec_out,
    output logic             busy
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_LOAD} state_t;

    state_t             r_state;
    logic               r_klr;
    logic [255:0]       r_key;
    logic [511:0]       r_sbox;
    logic [CW-1:0]      r_inflight;
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_mode;
    logic [TAG_W-1:0]   r_tag [LATENCY];
    logic [63:0]        r_fdata [FIFO_DEPTH];
    logic [TAG_W-1:0]   r_ftag [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fmode;
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [FW-1:0]      r_count;

    logic [31:0]        w_used;
    logic               w_accept;
    logic               w_exit;
    logic               w_pop;
    logic [63:0]        w_res;

    // Credit counts every block that will eventually occupy a FIFO slot.
    assign w_used    = 32'(r_inflight) + 32'(r_count);
    assign in_ready  = (r_state == S_RUN) && (w_used < 32'(FIFO_DEPTH))
                       && !key_load_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_exit    = r_vld[LATENCY-1];
    assign w_res     = r_mode[LATENCY-1] ? dec_out : enc_out;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = out_valid ? r_fdata[r_rptr] : '0;
    assign out_tag   = out_valid ? r_ftag[r_rptr] : '0;
    assign out_mode  = out_valid && r_fmode[r_rptr];
    assign pipe_in   = in_data;
    assign pipe_key  = r_key;
    assign pipe_sbox = r_sbox;
    assign key_load_ready = r_klr;
    assign busy      = (r_inflight != '0) || (r_count != '0);

    // Control FSM: drain the pipelines before swapping key material.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_klr   <= 1'b0;
            r_key   <= '0;
            r_sbox  <= '0;
        end else begin
            r_klr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (key_load_valid) begin
                        r_state <= S_LOAD;
                        r_klr   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (key_load_valid) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_state <= S_LOAD;
                        r_klr   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_key   <= key_in;
                    r_sbox  <= sbox_in;
                    r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // In-flight tracking shift registers and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld      <= '0;
            r_mode     <= '0;
            r_inflight <= '0;
            for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_vld[0]  <= w_accept;
            r_mode[0] <= in_mode;
            r_tag[0]  <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_mode[i] <= r_mode[i-1];
                r_tag[i]  <= r_tag[i-1];
            end
            if (w_accept && !w_exit) r_inflight <= r_inflight + CW'(1);
            else if (!w_accept && w_exit) r_inflight <= r_inflight - CW'(1);
        end
    end

    // FIFO pointers and count; credit makes a full-FIFO push impossible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_exit) begin
                assert (r_count != FW'(FIFO_DEPTH));
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            if (w_exit && !w_pop) r_count <= r_count + FW'(1);
            else if (!w_exit && w_pop) r_count <= r_count - FW'(1);
        end
    end

    // FIFO storage, written with the pipeline result selected by mode.
    always_ff @(posedge clk) begin
        if (w_exit) begin
            r_fdata[r_wptr] <= w_res;
            r_ftag[r_wptr]  <= r_tag[LATENCY-1];
            r_fmode[r_wptr] <= r_mode[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_gost89_ecb_stream_ctrl.sv
// Bench for gost89_ecb_stream_ctrl with a behavioural stand-in pipeline.
// Stand-in: enc = (x ^ S) + K, dec = (x - K) ^ S, key applied at pipe exit.
module tb_gost89_ecb_stream_ctrl;

    localparam int L  = 6;
    localparam int D  = 8;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          key_load_valid;
    logic          key_load_ready;
    logic [255:0]  key_in;
    logic [511:0]  sbox_in;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [63:0]   in_data;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [TW-1:0] out_tag;
    logic          out_mode;
    logic [255:0]  pipe_key;
    logic [511:0]  pipe_sbox;
    logic [63:0]   pipe_in;
    logic [63:0]   enc_out;
    logic [63:0]   dec_out;
    logic          busy;

    gost89_ecb_stream_ctrl #(
        .LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .key_load_valid(key_load_valid), .key_load_ready(key_load_ready),
        .key_in(key_in), .sbox_in(sbox_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_mode(out_mode),
        .pipe_key(pipe_key), .pipe_sbox(pipe_sbox), .pipe_in(pipe_in),
        .enc_out(enc_out), .dec_out(dec_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] r_d [L];
    always @(posedge clk) begin
        r_d[0] <= pipe_in;
        for (int i = 1; i < L; i++) r_d[i] <= r_d[i-1];
    end
    assign enc_out = (r_d[L-1] ^ pipe_sbox[63:0]) + pipe_key[63:0];
    assign dec_out = (r_d[L-1] - pipe_key[63:0]) ^ pipe_sbox[63:0];

    typedef logic [68:0] exp_t;
    exp_t        sb [$];
    logic [63:0] m_key;
    logic [63:0] m_sbox;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_klr = 0;
    bit          g_acc;
    logic [255:0] K_A, K_B;
    logic [511:0] S_A, S_B;

    task automatic chk(string tg, logic [127:0] got, logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tg, got, want);
        end
    endtask

    function automatic logic [63:0] f(logic [63:0] x, logic m);
        return m ? ((x - m_key) ^ m_sbox) : ((x ^ m_sbox) + m_key);
    endfunction

    task automatic next_blk();
        in_data = {$urandom(), $urandom()};
        in_mode = 1'($urandom_range(0, 1));
        in_tag  = TW'($urandom_range(0, 15));
    endtask

    // One clock cycle: predict accept/pop/load from settled signals.
    task automatic cyc();
        exp_t e;
        #1;
        g_acc = in_valid && in_ready;
        if (g_acc) begin
            sb.push_back({f(in_data, in_mode), in_tag, in_mode});
            n_acc++;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("out", {out_data, out_tag, out_mode}, e);
            end
        end
        if (key_load_ready) begin
            n_klr++;
            m_key  = key_in[63:0];
            m_sbox = sbox_in[63:0];
        end
        @(negedge clk);
    endtask

    task automatic drain(int max);
        for (int c = 0; c < max && sb.size() != 0; c++) cyc();
        chk("drain_empty", sb.size(), 0);
        #1 chk("drain_busy", busy, 0);
        @(negedge clk);
    endtask

    task automatic load_key(logic [255:0] k, logic [511:0] s);
        int k0;
        key_in = k;
        sbox_in = s;
        key_load_valid = 1'b1;
        k0 = n_klr;
        for (int c = 0; c < 200 && n_klr == k0; c++) cyc();
        key_load_valid = 1'b0;
        cyc();
        cyc();
        chk("kl_pulses", n_klr - k0, 1);
    endtask

    task automatic one_block(logic m, logic [63:0] d, logic [TW-1:0] t,
                             logic [63:0] want);
        int lat;
        int a0;
        in_valid = 1'b1;
        in_mode = m;
        in_data = d;
        in_tag = t;
        out_ready = 1'b0;
        a0 = n_acc;
        cyc();
        in_valid = 1'b0;
        chk("blk_acc", n_acc - a0, 1);
        lat = 1;
        while (lat < 100) begin
            #1;
            if (out_valid) break;
            lat++;
            @(negedge clk);
        end
        chk("blk_lat", lat, L + 1);
        chk("blk_data", out_data, want);
        chk("blk_tag", out_tag, t);
        chk("blk_mode", out_mode, m);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        int a0;
        int k0;
        int drops;
        int nv;
        int na;
        K_A = {4{64'h0123456789ABCDEF}};
        S_A = {8{64'h1111111111111111}};
        K_B = {4{64'hFEDCBA9876543210}};
        S_B = {8{64'h0F0F0F0F0F0F0F0F}};
        m_key = '0;
        m_sbox = '0;
        rst = 1'b1;
        key_load_valid = 1'b0;
        key_in = '0;
        sbox_in = '0;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_data = '0;
        in_tag = '0;
        out_ready = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_klr", key_load_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_pipe_key", pipe_key[127:0], 0);
        chk("rst_pipe_sbox", pipe_sbox[127:0], 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        in_valid = 1'b1;
        #1 chk("idle_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;

        key_in = K_A;
        sbox_in = S_A;
        key_load_valid = 1'b1;
        #1 chk("kl_t0", key_load_ready, 0);
        @(negedge clk);
        #1 chk("kl_t1", key_load_ready, 1);
        @(negedge clk);
        key_load_valid = 1'b0;
        #1;
        chk("kl_t2_klr", key_load_ready, 0);
        chk("kl_t2_in_ready", in_ready, 1);
        chk("kl_pipe_key", pipe_key[63:0], 64'h0123456789ABCDEF);
        chk("kl_pipe_sbox", pipe_sbox[63:0], 64'h1111111111111111);
        m_key = K_A[63:0];
        m_sbox = S_A[63:0];
        @(negedge clk);

        one_block(1'b0, 64'h0, 4'h5, 64'h123456789ABCDF00);
        one_block(1'b1, 64'h123456789ABCDF00, 4'h9, 64'h0);

        out_ready = 1'b1;
        in_valid = 1'b1;
        next_blk();
        drops = 0;
        a0 = n_acc;
        for (int c = 0; c < 400 && n_acc - a0 < 200; c++) begin
            cyc();
            if (!g_acc) drops++;
            else next_blk();
        end
        in_valid = 1'b0;
        chk("b2b_acc", n_acc - a0, 200);
        chk("b2b_drops", drops, 0);
        drain(60);

        out_ready = 1'b0;
        in_valid = 1'b1;
        next_blk();
        a0 = n_acc;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (g_acc) next_blk();
        end
        in_valid = 1'b0;
        chk("bp_acc", n_acc - a0, D);
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a0 = n_acc;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (g_acc) break;
        end
        in_valid = 1'b0;
        chk("bp_resume", n_acc - a0, 1);
        drain(60);

        out_ready = 1'b1;
        in_valid = 1'b1;
        next_blk();
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (g_acc) next_blk();
        end
        key_in = K_B;
        sbox_in = S_B;
        key_load_valid = 1'b1;
        #1;
        chk("kc_in_ready", in_ready, 0);
        chk("kc_busy", busy, 1);
        a0 = n_acc;
        k0 = n_klr;
        for (int c = 0; c < 100 && n_klr == k0; c++) cyc();
        key_load_valid = 1'b0;
        chk("kc_no_acc", n_acc - a0, 0);
        a0 = n_acc;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (g_acc) next_blk();
        end
        in_valid = 1'b0;
        chk("kc_pulses", n_klr - k0, 1);
        chk("kc_new_acc", (n_acc - a0) > 0, 1);
        drain(60);

        out_ready = 1'b0;
        in_valid = 1'b1;
        next_blk();
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (g_acc) next_blk();
        end
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_out_tag", out_tag, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_pipe_key", pipe_key[127:0], 0);
        chk("mrst_klr", key_load_ready, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        nv = 0;
        na = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (out_valid) nv++;
            if (in_ready) na++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mrst_no_out", nv, 0);
        chk("mrst_no_acc", na, 0);
        load_key(K_A, S_A);
        one_block(1'b0, 64'h0, 4'h3, 64'h123456789ABCDF00);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
